// File: rtl/exp_acc_host.sv
// Host-side sequencer for an iterative accelerator: queues user requests,
// launches one computation at a time, collects its result and aborts on timeout.
module exp_acc_host #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned PEND_MAX = 7,
  localparam int unsigned DW = 18,
  localparam int unsigned PW = 3,
  localparam int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          done_i,
  input  logic          ready_i,
  input  logic [DW-1:0] q_i,
  output logic          start_o,
  output logic          read_o,
  output logic [DW-1:0] result_o,
  output logic          result_valid_o,
  output logic          busy_o,
  output logic          err_o,
  output logic [PW-1:0] pending_o,
  output logic [CW-1:0] count_o
);

  // Wide enough to hold TIMEOUT itself, never zero bits.
  localparam int unsigned WW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_READ,
    S_WAIT_READY
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] result_q, result_d;
  logic          start_q, start_d;
  logic          read_q, read_d;
  logic          rv_q, rv_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          deq;
  logic          accept;
  logic          wait_hit;

  // Last cycle allowed in a wait state: the TIMEOUT-th cycle since entry.
  assign wait_hit = (wait_q == WW'(TIMEOUT - 1));

  // Next-state, datapath and queue bookkeeping.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    result_d = result_q;
    count_d  = count_q;
    err_d    = err_q;
    rv_d     = 1'b0;
    deq      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d = S_START;
          deq     = 1'b1;
        end
      end
      S_START: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        wait_d = wait_q + WW'(1);
        if (done_i) begin
          state_d = S_READ;
        end else if (wait_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_READ: state_d = S_WAIT_READY;
      S_WAIT_READY: begin
        wait_d = wait_q + WW'(1);
        if (ready_i) begin
          result_d = q_i;
          rv_d     = 1'b1;
          count_d  = count_q + CW'(1);
          state_d  = S_IDLE;
        end else if (wait_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A dequeue in the same cycle frees a slot, so a full queue still accepts.
    accept    = req_i && ((pending_q < PW'(PEND_MAX)) || deq);
    pending_d = pending_q;
    if (accept && !deq) begin
      pending_d = pending_q + PW'(1);
    end else if (!accept && deq) begin
      pending_d = pending_q - PW'(1);
    end

    start_d = (state_d == S_START);
    read_d  = (state_d == S_READ) || (state_d == S_WAIT_READY);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      pending_q <= '0;
      count_q   <= '0;
      result_q  <= '0;
      start_q   <= 1'b0;
      read_q    <= 1'b0;
      rv_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      result_q  <= result_d;
      start_q   <= start_d;
      read_q    <= read_d;
      rv_q      <= rv_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign start_o        = start_q;
  assign read_o         = read_q;
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;
  assign pending_o      = pending_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_exp_acc_host.sv
// Self-checking bench for exp_acc_host: an accelerator responder plus a
// transaction-level reference (queued work, ordered results, counts).
module tb_exp_acc_host;

  localparam int unsigned TO = 15;
  localparam int unsigned PMAX = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        done = 1'b0;
  logic        ready = 1'b0;
  logic [17:0] q = '0;
  logic        start, rd, rv, busy, err;
  logic [17:0] result;
  logic [2:0]  pending;
  logic [7:0]  count;

  int checks = 0;
  int failures = 0;

  // Responder configuration
  bit          fix_dly = 1'b0;
  int          cfg_dd = 1;
  int          cfg_rd = 1;
  bit          use_fix_q = 1'b0;
  logic [17:0] cfg_q = '0;
  int          skip_done = 0;
  int          skip_ready = 0;
  logic [17:0] acc_sent[$];

  // Monitor bookkeeping
  int          n_start = 0;
  int          n_rv = 0;
  int          gap_viol = 0;
  int          overlap = 0;
  longint      cyc = 0;
  longint      last_start = -1;
  logic [17:0] rv_q[$];

  exp_acc_host #(.TIMEOUT(TO), .PEND_MAX(PMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done), .ready_i(ready), .q_i(q),
    .start_o(start), .read_o(rd), .result_o(result), .result_valid_o(rv),
    .busy_o(busy), .err_o(err), .pending_o(pending), .count_o(count)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last_start = -1;
      end else begin
        if (start) begin
          if (last_start >= 0 && cyc - last_start < 5) gap_viol++;
          last_start = cyc;
          n_start++;
        end
        if (start && rd) overlap++;
        if (rv) begin
          n_rv++;
          rv_q.push_back(result);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Accelerator: done dd cycles after start, ready rd cycles after read rises.
  task automatic serve();
    int dd, rdl;
    dd  = fix_dly ? cfg_dd : int'($urandom_range(1, 8));
    rdl = fix_dly ? cfg_rd : int'($urandom_range(1, 8));
    if (skip_done > 0) begin skip_done--; return; end
    for (int i = 0; i < dd; i++) begin @(negedge clk); if (!rst_n) return; end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    if (!rst_n) return;
    if (skip_ready > 0) begin skip_ready--; return; end
    for (int i = 0; i < rdl; i++) begin @(negedge clk); if (!rst_n) return; end
    q = use_fix_q ? cfg_q : 18'($urandom);
    ready = 1'b1;
    acc_sent.push_back(q);
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    req = 1'b0; done = 1'b0; ready = 1'b0; skip_done = 0; skip_ready = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && pending == 3'd0 && !start) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({start, rd, rv, busy, err} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {start, rd, rv, busy, err}); end
    checks++; if (result !== 18'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if ({pending, count} !== 11'd0) begin failures++; $display("FAIL reset_pend_count got=%0d/%0d exp=0/0", pending, count); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({busy, start, pending} !== 5'd0) begin failures++; $display("FAIL reset_no_start got=%b exp=00000", {busy, start, pending}); end
  endtask

  task automatic test_single();
    int s0, r0, b;
    bit ok;
    do_reset();
    fix_dly = 1'b1; cfg_dd = 3; cfg_rd = 2; use_fix_q = 1'b1; cfg_q = 18'h2A5F;
    #1; s0 = n_start; r0 = n_rv; b = rv_q.size();
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    #1;
    checks++; if ({busy, pending} !== {1'b0, 3'd1}) begin failures++; $display("FAIL single_queued got=%b exp=0001", {busy, pending}); end
    @(negedge clk); #1;
    checks++; if ({start, busy, pending} !== {2'b11, 3'd0}) begin failures++; $display("FAIL single_start got=%b exp=11000", {start, busy, pending}); end
    @(negedge clk); #1;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", start); end
    repeat (3) @(negedge clk); #1;
    checks++; if (rd !== 1'b1) begin failures++; $display("FAIL single_read got=%b exp=1", rd); end
    repeat (3) @(negedge clk); #1;
    checks++; if ({rv, rd} !== 2'b10 || result !== 18'h2A5F || count !== 8'd1) begin failures++; $display("FAIL single_capture got rv=%b rd=%b res=%h cnt=%0d exp rv=1 rd=0 res=2a5f cnt=1", rv, rd, result, count); end
    @(negedge clk); #1;
    checks++; if ({rv, busy} !== 2'b00) begin failures++; $display("FAIL single_after got=%b exp=00", {rv, busy}); end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle_timeout got=busy exp=idle"); end
    checks++; if (n_start - s0 != 1 || n_rv - r0 != 1) begin failures++; $display("FAIL single_pulses got=%0d/%0d exp=1/1", n_start - s0, n_rv - r0); end
    checks++; if (rv_q.size() != b + 1 || rv_q[rv_q.size() - 1] !== 18'h2A5F) begin failures++; $display("FAIL single_rv_value got=%h exp=2a5f", rv_q[rv_q.size() - 1]); end
  endtask

  task automatic test_ignore();
    int r0, s0;
    logic [7:0]  c0;
    logic [17:0] res0;
    #1; r0 = n_rv; s0 = n_start; c0 = count; res0 = result;
    @(negedge clk);
    done = 1'b1; ready = 1'b1; q = 18'($urandom);
    repeat (3) @(negedge clk);
    done = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || count !== c0 || result !== res0) begin failures++; $display("FAIL ignore_state got busy=%b cnt=%0d res=%h exp busy=0 cnt=%0d res=%h", busy, count, result, c0, res0); end
    checks++; if (n_rv != r0 || n_start != s0) begin failures++; $display("FAIL ignore_pulses got=%0d/%0d exp=%0d/%0d", n_rv, n_start, r0, s0); end
  endtask

  task automatic test_overflow();
    int s0, a, b, g0, o0, exp_starts, mism;
    bit ok;
    do_reset();
    fix_dly = 1'b1; cfg_dd = 6; cfg_rd = 4; use_fix_q = 1'b0;
    #1; s0 = n_start; a = acc_sent.size(); b = rv_q.size(); g0 = gap_viol; o0 = overlap;
    exp_starts = 1 + ((9 < int'(PMAX)) ? 9 : int'(PMAX));
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); #1;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL ovf_first_start got=%b exp=1", start); end
    req = 1'b1;
    repeat (9) @(negedge clk);
    req = 1'b0;
    #1;
    checks++; if (pending !== 3'(PMAX)) begin failures++; $display("FAIL ovf_saturate got=%0d exp=%0d", pending, PMAX); end
    wait_idle(600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_idle_timeout got=busy exp=idle"); end
    checks++; if (n_start - s0 != exp_starts) begin failures++; $display("FAIL ovf_starts got=%0d exp=%0d", n_start - s0, exp_starts); end
    checks++; if (count !== 8'(exp_starts)) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", count, exp_starts); end
    checks++; if (gap_viol != g0 || overlap != o0) begin failures++; $display("FAIL ovf_spacing got viol=%0d ovl=%0d exp=0/0", gap_viol - g0, overlap - o0); end
    mism = 0;
    for (int i = 0; i < exp_starts; i++) if (rv_q[b + i] !== acc_sent[a + i]) mism++;
    checks++; if (rv_q.size() - b != exp_starts || mism != 0) begin failures++; $display("FAIL ovf_results got n=%0d bad=%0d exp n=%0d bad=0", rv_q.size() - b, mism, exp_starts); end
  endtask

  task automatic test_simul();
    int s0;
    bit ok, found;
    do_reset();
    fix_dly = 1'b1; cfg_dd = 4; cfg_rd = 3; use_fix_q = 1'b0;
    #1; s0 = n_start;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); #1;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL simul_first_start got=%b exp=1", start); end
    req = 1'b1;
    repeat (2) @(negedge clk);
    req = 1'b0;
    #1;
    checks++; if (pending !== 3'd2) begin failures++; $display("FAIL simul_pend2 got=%0d exp=2", pending); end
    // The result_valid cycle is the idle cycle in which the next dequeue happens.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (rv) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL simul_rv_wait got=none exp=pulse"); end
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    #1;
    checks++; if (pending !== 3'd2 || start !== 1'b1) begin failures++; $display("FAIL simul_hold got pend=%0d start=%b exp pend=2 start=1", pending, start); end
    wait_idle(400, ok);
    checks++; if (!ok || n_start - s0 != 4 || count !== 8'd4) begin failures++; $display("FAIL simul_drain got ok=%b starts=%0d cnt=%0d exp 1/4/4", ok, n_start - s0, count); end
  endtask

  task automatic test_timeout();
    int n, r0;
    bit ok, found;
    logic [7:0]  c0;
    logic [17:0] res0;
    do_reset();
    fix_dly = 1'b0; use_fix_q = 1'b0; skip_done = 1;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); #1;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", start); end
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) req = 1'b1;
      if (i == 3) req = 1'b0;
      #1;
      if (err) begin n = i; break; end
    end
    checks++; if (n != int'(TO) + 1) begin failures++; $display("FAIL to_err_cycle got=%0d exp=%0d", n, TO + 1); end
    checks++; if (busy !== 1'b0 || count !== 8'd0 || result !== 18'd0) begin failures++; $display("FAIL to_abort got busy=%b cnt=%0d res=%h exp 0/0/0", busy, count, result); end
    @(negedge clk); #1;
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL to_next_start got=%b exp=1", start); end
    wait_idle(200, ok);
    checks++; if (!ok || count !== 8'd1 || err !== 1'b1 || result !== acc_sent[$]) begin failures++; $display("FAIL to_recover got ok=%b cnt=%0d err=%b res=%h exp 1/1/1/%h", ok, count, err, result, acc_sent[$]); end
    // Same abort path from the result-wait state.
    c0 = count; res0 = result; r0 = n_rv; skip_ready = 1;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rd) begin found = 1'b1; break; end
    end
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); #1;
      if (!rd) begin n = i; break; end
    end
    checks++; if (!found || n != int'(TO) + 1) begin failures++; $display("FAIL to_read_drop got found=%b n=%0d exp 1/%0d", found, n, TO + 1); end
    checks++; if (busy !== 1'b0 || count !== c0 || result !== res0) begin failures++; $display("FAIL to_ready_abort got busy=%b cnt=%0d res=%h exp 0/%0d/%h", busy, count, result, c0, res0); end
    @(negedge clk); #1;
    checks++; if (n_rv != r0) begin failures++; $display("FAIL to_no_rv got=%0d exp=%0d", n_rv, r0); end
  endtask

  task automatic test_reset_mid();
    int s0, r0;
    bit found;
    do_reset();
    fix_dly = 1'b1; cfg_dd = 2; cfg_rd = 5; use_fix_q = 1'b0;
    #1; s0 = n_start; r0 = n_rv;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rd) begin found = 1'b1; break; end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (!found || rd !== 1'b0) begin failures++; $display("FAIL rmid_read got found=%b rd=%b exp 1/0", found, rd); end
    checks++; if ({start, rv, busy, err, pending, count, result} !== 33'd0) begin failures++; $display("FAIL rmid_outputs got=%h exp=0", {start, rv, busy, err, pending, count, result}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || pending !== 3'd0 || n_start - s0 != 1 || n_rv != r0 || result !== 18'd0) begin failures++; $display("FAIL rmid_after got busy=%b pend=%0d starts=%0d rvs=%0d res=%h exp 0/0/1/0/0", busy, pending, n_start - s0, n_rv - r0, result); end
  endtask

  task automatic test_count_wrap();
    int s0, a, b, g0, o0, issued, burst, mism, exp_count;
    logic [7:0] c0;
    bit ok, ok_all;
    do_reset();
    fix_dly = 1'b0; use_fix_q = 1'b0;
    #1; s0 = n_start; a = acc_sent.size(); b = rv_q.size(); g0 = gap_viol; o0 = overlap; c0 = count;
    issued = 0; ok_all = 1'b1;
    while (issued < 256) begin
      burst = int'($urandom_range(1, 5));
      if (burst > 256 - issued) burst = 256 - issued;
      for (int j = 0; j < burst; j++) begin
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      issued += burst;
      wait_idle(500, ok);
      if (!ok) ok_all = 1'b0;
    end
    exp_count = (int'(c0) + issued) % 256;
    checks++; if (!ok_all) begin failures++; $display("FAIL wrap_idle_timeout got=busy exp=idle"); end
    checks++; if (n_start - s0 != 256) begin failures++; $display("FAIL wrap_starts got=%0d exp=256", n_start - s0); end
    checks++; if (count !== 8'(exp_count)) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", count, exp_count); end
    checks++; if (result !== acc_sent[$] || err !== 1'b0) begin failures++; $display("FAIL wrap_final got res=%h err=%b exp res=%h err=0", result, err, acc_sent[$]); end
    checks++; if (gap_viol != g0 || overlap != o0) begin failures++; $display("FAIL wrap_spacing got viol=%0d ovl=%0d exp=0/0", gap_viol - g0, overlap - o0); end
    checks++; if (rv_q.size() - b != 256 || acc_sent.size() - a != 256) begin failures++; $display("FAIL wrap_result_count got=%0d/%0d exp=256/256", rv_q.size() - b, acc_sent.size() - a); end
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (rv_q[b + i] !== acc_sent[a + i]) begin
        failures++; mism++;
        if (mism <= 5) $display("FAIL wrap_result[%0d] got=%h exp=%h", i, rv_q[b + i], acc_sent[a + i]);
      end
    end
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          if (rst_n && start) serve();
        end
      end
      begin
        test_reset();
        test_single();
        test_ignore();
        test_overflow();
        test_simul();
        test_timeout();
        test_reset_mid();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
